stat_pkt_multi: RTL and testbench

Per-flow packet statistics engine, successor to the single-counter flow statistics block. For each of 2^A_WIDTH flows it keeps a byte counter and a packet counter in one dual-port RAM word. Updates are accumulated through a read-modify-write pipeline with hazard forwarding. A host read port returns both counters, optionally clearing them atomically. Sits after the packet classifier, and its read port faces the CPU register bridge.

---
 rtl/stat_pkt_multi.sv | 197 +++++++++++++++++++
 tb/tb_stat_pkt_multi.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stat_pkt_multi.sv
// stat_pkt_multi
// Per-flow packet statistics engine. Each of 2^A_WIDTH flows owns one RAM
// word holding {byte counter, packet counter}. Packet updates pass through a
// three-stage read-modify-write pipeline (input register, RAM read, add and
// write back). A host read port snapshots both counters of one flow and can
// clear them atomically.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   rx_flow_num_i           flow index of the packet update
//   pkt_size_i              packet length in bytes
//   pkt_size_ena_i          update strobe (one packet per cycle)
//   rd_stb_i                read request, taken only while rd_busy_o = 0
//   rd_flow_num_i           flow to read
//   rd_clear_i              clear the flow after reading it
//   rd_busy_o               RAM init running or read outstanding
//   rd_bytes_o, rd_pkts_o   read result, held until the next result
//   rd_data_val_o           one-cycle result strobe
//   init_done_o             RAM clear after reset has finished
module stat_pkt_multi #(
  parameter int A_WIDTH  = 10,
  parameter int SIZE_W   = 16,
  parameter int BYTE_W   = 32,
  parameter int PKT_W    = 24,
  parameter bit SATURATE = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [A_WIDTH-1:0] rx_flow_num_i,
  input  logic [SIZE_W-1:0]  pkt_size_i,
  input  logic               pkt_size_ena_i,
  input  logic               rd_stb_i,
  input  logic [A_WIDTH-1:0] rd_flow_num_i,
  input  logic               rd_clear_i,
  output logic               rd_busy_o,
  output logic [BYTE_W-1:0]  rd_bytes_o,
  output logic [PKT_W-1:0]   rd_pkts_o,
  output logic               rd_data_val_o,
  output logic               init_done_o
);

  localparam int DEPTH  = 1 << A_WIDTH;
  localparam int WORD_W = BYTE_W + PKT_W;

  typedef enum logic [1:0] {INIT, IDLE, RD_REQ, RD_DATA} state_t;

  state_t             state, state_nxt;
  logic [A_WIDTH-1:0] init_addr;

  logic               s1_vld, s2_vld;
  logic [A_WIDTH-1:0] s1_flow, s2_flow;
  logic [SIZE_W-1:0]  s1_size, s2_size;

  logic [A_WIDTH-1:0] rd_flow;
  logic               rd_clear;
  logic               rd_accept;

  logic [WORD_W-1:0]  mem [DEPTH];
  logic               ram_we;
  logic [A_WIDTH-1:0] ram_waddr, ram_raddr;
  logic [WORD_W-1:0]  ram_wdata, ram_q;
  logic               byp_vld;
  logic [WORD_W-1:0]  byp_data;

  logic [WORD_W-1:0]  cur_word;
  logic [BYTE_W-1:0]  cur_bytes, new_bytes;
  logic [PKT_W-1:0]   cur_pkts, new_pkts;
  logic [BYTE_W:0]    byte_sum;
  logic [PKT_W:0]     pkt_sum;

  assign init_done_o = (state != INIT);
  assign rd_accept   = (state == IDLE) && rd_stb_i && !rd_data_val_o;

  // FSM state register; reset always restarts the RAM clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= INIT;
    else       state <= state_nxt;
  end

  // FSM next-state logic. A read issues only in a cycle where S1 is empty,
  // because updates own the RAM read port.
  always_comb begin
    state_nxt = state;
    unique case (state)
      INIT:    if (&init_addr) state_nxt = IDLE;
      IDLE:    if (rd_accept)  state_nxt = RD_REQ;
      RD_REQ:  if (!s1_vld)    state_nxt = RD_DATA;
      RD_DATA: state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  // FSM outputs: RAM port steering and the busy flag. Busy also covers the
  // result cycle so a new request is only taken once the result is out.
  // The read issued from RD_REQ found S1 empty, so S2 is empty in RD_DATA and
  // the clear write there never competes with an update write.
  always_comb begin
    ram_we    = s2_vld;
    ram_waddr = s2_flow;
    ram_wdata = {new_bytes, new_pkts};
    ram_raddr = s1_flow;
    rd_busy_o = 1'b1;
    unique case (state)
      INIT: begin
        ram_we    = 1'b1;
        ram_waddr = init_addr;
        ram_wdata = '0;
      end
      IDLE:    rd_busy_o = rd_data_val_o;
      RD_REQ:  if (!s1_vld) ram_raddr = rd_flow;
      RD_DATA: if (rd_clear) begin
        ram_we    = 1'b1;
        ram_waddr = rd_flow;
        ram_wdata = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)               init_addr <= '0;
    else if (state == INIT)  init_addr <= init_addr + 1'b1;
  end

  // Update pipeline. Packets arriving while the RAM is being cleared are dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_vld  <= 1'b0;
      s1_flow <= '0;
      s1_size <= '0;
      s2_vld  <= 1'b0;
      s2_flow <= '0;
      s2_size <= '0;
    end else begin
      s1_vld  <= pkt_size_ena_i && (state != INIT);
      s1_flow <= rx_flow_num_i;
      s1_size <= pkt_size_i;
      s2_vld  <= s1_vld;
      s2_flow <= s1_flow;
      s2_size <= s1_size;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_flow  <= '0;
      rd_clear <= 1'b0;
    end else if (rd_accept) begin
      rd_flow  <= rd_flow_num_i;
      rd_clear <= rd_clear_i;
    end
  end

  // Dual-port RAM with read-old-data behaviour on an address collision.
  always_ff @(posedge clk_i) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_q <= mem[ram_raddr];
  end

  // Any write landing on the address being read in the same cycle is
  // forwarded, so S2 sees the freshest value for back-to-back same-flow
  // updates and for a flow that was just cleared.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      byp_vld  <= 1'b0;
      byp_data <= '0;
    end else begin
      byp_vld  <= ram_we && (ram_waddr == ram_raddr);
      byp_data <= ram_wdata;
    end
  end

  assign cur_word  = byp_vld ? byp_data : ram_q;
  assign cur_bytes = cur_word[WORD_W-1:PKT_W];
  assign cur_pkts  = cur_word[PKT_W-1:0];

  // One extra bit on each sum exposes the carry used for clamping.
  assign byte_sum  = {1'b0, cur_bytes} + {{(BYTE_W + 1 - SIZE_W){1'b0}}, s2_size};
  assign pkt_sum   = {1'b0, cur_pkts} + {{PKT_W{1'b0}}, 1'b1};
  assign new_bytes = (SATURATE && byte_sum[BYTE_W]) ? {BYTE_W{1'b1}} : byte_sum[BYTE_W-1:0];
  assign new_pkts  = (SATURATE && pkt_sum[PKT_W])   ? {PKT_W{1'b1}}  : pkt_sum[PKT_W-1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_val_o <= 1'b0;
      rd_bytes_o    <= '0;
      rd_pkts_o     <= '0;
    end else begin
      rd_data_val_o <= (state == RD_DATA);
      if (state == RD_DATA) begin
        rd_bytes_o <= cur_bytes;
        rd_pkts_o  <= cur_pkts;
      end
    end
  end

endmodule

// File: tb/tb_stat_pkt_multi.sv
// tb_stat_pkt_multi
// Self-checking bench for stat_pkt_multi. The main instance uses default
// parameters and is compared every cycle against a per-flow totals model.
// Two small instances (17-bit byte and 2-bit packet counters) cover
// saturation and wrap-around.
module tb_stat_pkt_multi;

  localparam int AW    = 10;
  localparam int NFLOW = 1 << AW;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [AW-1:0] rx_flow_num;
  logic [15:0]   pkt_size;
  logic          pkt_size_ena;
  logic          rd_stb;
  logic [AW-1:0] rd_flow_num;
  logic          rd_clear;
  logic          rd_busy;
  logic [31:0]   rd_bytes;
  logic [23:0]   rd_pkts;
  logic          rd_data_val;
  logic          init_done;

  logic [2:0]    sm_flow;
  logic [15:0]   sm_size;
  logic          sm_ena, sm_stb, sm_clr;
  logic          sat_busy, sat_val, sat_init, wrap_busy, wrap_val, wrap_init;
  logic [16:0]   sat_bytes, wrap_bytes;
  logic [1:0]    sat_pkts, wrap_pkts;

  always #5 clk_i = ~clk_i;

  stat_pkt_multi dut (
    .clk_i(clk_i), .rst_i(rst_i), .rx_flow_num_i(rx_flow_num), .pkt_size_i(pkt_size),
    .pkt_size_ena_i(pkt_size_ena), .rd_stb_i(rd_stb), .rd_flow_num_i(rd_flow_num),
    .rd_clear_i(rd_clear), .rd_busy_o(rd_busy), .rd_bytes_o(rd_bytes), .rd_pkts_o(rd_pkts),
    .rd_data_val_o(rd_data_val), .init_done_o(init_done)
  );

  stat_pkt_multi #(.A_WIDTH(3), .SIZE_W(16), .BYTE_W(17), .PKT_W(2), .SATURATE(1'b1)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i), .rx_flow_num_i(sm_flow), .pkt_size_i(sm_size),
    .pkt_size_ena_i(sm_ena), .rd_stb_i(sm_stb), .rd_flow_num_i(sm_flow),
    .rd_clear_i(sm_clr), .rd_busy_o(sat_busy), .rd_bytes_o(sat_bytes), .rd_pkts_o(sat_pkts),
    .rd_data_val_o(sat_val), .init_done_o(sat_init)
  );

  stat_pkt_multi #(.A_WIDTH(3), .SIZE_W(16), .BYTE_W(17), .PKT_W(2), .SATURATE(1'b0)) dut_wrap (
    .clk_i(clk_i), .rst_i(rst_i), .rx_flow_num_i(sm_flow), .pkt_size_i(sm_size),
    .pkt_size_ena_i(sm_ena), .rd_stb_i(sm_stb), .rd_flow_num_i(sm_flow),
    .rd_clear_i(sm_clr), .rd_busy_o(wrap_busy), .rd_bytes_o(wrap_bytes), .rd_pkts_o(wrap_pkts),
    .rd_data_val_o(wrap_val), .init_done_o(wrap_init)
  );

  int     n_checks = 0;
  int     n_fail   = 0;

  // Reference model: running totals per flow since the last clear, plus the
  // state of one outstanding read.
  longint tot_bytes [NFLOW];
  longint tot_pkts  [NFLOW];
  bit     m_waiting;
  int     m_flow;
  bit     m_clr;
  int     cyc;
  int     done_cycle;
  longint pend_bytes, pend_pkts, held_bytes, held_pkts;

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic longint fieldValue(input longint total, input int w, input bit sat);
    longint maxv;
    maxv = (longint'(1) << w) - 1;
    if (sat) return (total > maxv) ? maxv : total;
    return total & maxv;
  endfunction

  function automatic void modelReset();
    foreach (tot_bytes[i]) begin
      tot_bytes[i] = 0;
      tot_pkts[i]  = 0;
    end
    m_waiting  = 1'b0;
    cyc        = 0;
    done_cycle = -1;
    held_bytes = 0;
    held_pkts  = 0;
  endfunction

  // One clock cycle of the main instance: check the outputs of this cycle,
  // drive this cycle's inputs, then advance the model. A read snapshots at
  // the first cycle (at or after the request) carrying no packet update and
  // reports three cycles later.
  task automatic applyStimulus(input bit upd, input int flow, input int size,
                               input bit stb, input int rflow, input bit clr);
    bit exp_busy;
    @(negedge clk_i);
    exp_busy = m_waiting || (cyc <= done_cycle);
    if (cyc == done_cycle) begin
      held_bytes = pend_bytes;
      held_pkts  = pend_pkts;
    end
    checkOutput("busy", rd_busy, exp_busy);
    checkOutput("data_val", rd_data_val, cyc == done_cycle);
    checkOutput("bytes", rd_bytes, held_bytes);
    checkOutput("pkts", rd_pkts, held_pkts);
    pkt_size_ena = upd;
    rx_flow_num  = AW'(flow);
    pkt_size     = 16'(size);
    rd_stb       = stb;
    rd_flow_num  = AW'(rflow);
    rd_clear     = clr;
    if (stb && !exp_busy) begin
      m_waiting = 1'b1;
      m_flow    = rflow;
      m_clr     = clr;
    end
    if (m_waiting && !upd) begin
      pend_bytes = fieldValue(tot_bytes[m_flow], 32, 1'b1);
      pend_pkts  = fieldValue(tot_pkts[m_flow], 24, 1'b1);
      if (m_clr) begin
        tot_bytes[m_flow] = 0;
        tot_pkts[m_flow]  = 0;
      end
      done_cycle = cyc + 3;
      m_waiting  = 1'b0;
    end
    if (upd) begin
      tot_bytes[flow] += size;
      tot_pkts[flow]  += 1;
    end
    cyc++;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic startReset();
    rst_i = 1'b1;
    pkt_size_ena = 1'b0;
    rd_stb = 1'b0;
    rd_clear = 1'b0;
    #1;
    checkOutput("rst_busy", rd_busy, 1);
    checkOutput("rst_val", rd_data_val, 0);
    checkOutput("rst_bytes", rd_bytes, 0);
    checkOutput("rst_pkts", rd_pkts, 0);
    checkOutput("rst_init_done", init_done, 0);
  endtask

  // Release reset and follow the RAM clear cycle by cycle. Optionally feed
  // packets to flow 5 during the first half, which must be dropped.
  task automatic waitInit(input bit feed);
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int k = 1; k <= NFLOW; k++) begin
      @(posedge clk_i);
      #1;
      checkOutput("init_done", init_done, k == NFLOW);
      checkOutput("init_busy", rd_busy, k < NFLOW);
      checkOutput("init_val", rd_data_val, 0);
      pkt_size_ena = feed && (k < NFLOW / 2);
      rx_flow_num  = AW'(5);
      pkt_size     = 16'd77;
    end
    pkt_size_ena = 1'b0;
    modelReset();
  endtask

  task automatic smallStep(input bit ena, input int size);
    @(negedge clk_i);
    sm_ena  = ena;
    sm_size = 16'(size);
    sm_stb  = 1'b0;
    sm_clr  = 1'b0;
  endtask

  task automatic smallRead(input bit clr, input longint tb, input longint tp, input string tag);
    int wait_cnt;
    @(negedge clk_i);
    sm_ena = 1'b0;
    sm_stb = 1'b1;
    sm_clr = clr;
    @(negedge clk_i);
    sm_stb = 1'b0;
    sm_clr = 1'b0;
    wait_cnt = 1;
    while (sat_val !== 1'b1 && wait_cnt < 10) begin
      @(negedge clk_i);
      wait_cnt++;
    end
    checkOutput({tag, "_latency"}, wait_cnt, 3);
    checkOutput({tag, "_wrap_val"}, wrap_val, 1);
    checkOutput({tag, "_sat_bytes"}, sat_bytes, fieldValue(tb, 17, 1'b1));
    checkOutput({tag, "_sat_pkts"}, sat_pkts, fieldValue(tp, 2, 1'b1));
    checkOutput({tag, "_wrap_bytes"}, wrap_bytes, fieldValue(tb, 17, 1'b0));
    checkOutput({tag, "_wrap_pkts"}, wrap_pkts, fieldValue(tp, 2, 1'b0));
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: observed no completion, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_i = 1'b1;
    rx_flow_num = '0;
    pkt_size = '0;
    pkt_size_ena = 1'b0;
    rd_stb = 1'b0;
    rd_flow_num = '0;
    rd_clear = 1'b0;
    sm_flow = 3'd1;
    sm_size = '0;
    sm_ena = 1'b0;
    sm_stb = 1'b0;
    sm_clr = 1'b0;
    modelReset();

    $display("[TB] reset, RAM clear timing, dropped updates");
    startReset();
    waitInit(1'b1);
    applyStimulus(1'b0, 0, 0, 1'b1, 5, 1'b0);
    idleCycles(4);

    $display("[TB] back-to-back same-flow updates");
    applyStimulus(1'b1, 3, 64, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, 3, 100, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, 3, 1500, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, 0, 0, 1'b1, 3, 1'b0);
    idleCycles(4);
    checkOutput("t2_bytes", rd_bytes, 1664);
    checkOutput("t2_pkts", rd_pkts, 3);

    $display("[TB] read-clear racing updates");
    applyStimulus(1'b1, 3, 200, 1'b1, 3, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 3, 200, 1'b0, 0, 1'b0);
    idleCycles(4);
    checkOutput("t3_first_bytes", rd_bytes, 2464);
    checkOutput("t3_first_pkts", rd_pkts, 7);
    applyStimulus(1'b1, 3, 200, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, 3, 200, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, 0, 0, 1'b1, 3, 1'b0);
    idleCycles(4);
    checkOutput("t3_second_bytes", rd_bytes, 400);
    checkOutput("t3_second_pkts", rd_pkts, 2);

    $display("[TB] read held off by continuous traffic");
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, (k % 3 == 0) ? 7 : 3, (k == 0) ? 0 : int'($urandom_range(1500)),
                    (k == 2) || (k == 5), (k == 2) ? 7 : 3, k == 5);
    end
    idleCycles(6);
    applyStimulus(1'b0, 0, 0, 1'b1, 3, 1'b0);
    idleCycles(4);

    $display("[TB] reset during a read and during RAM clear");
    applyStimulus(1'b0, 0, 0, 1'b1, 3, 1'b0);
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b0);
    startReset();
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (100) @(posedge clk_i);
    #1;
    startReset();
    waitInit(1'b0);
    idleCycles(3);
    applyStimulus(1'b0, 0, 0, 1'b1, 3, 1'b0);
    idleCycles(4);

    $display("[TB] randomized traffic and reads");
    for (int k = 0; k < 2000; k++) begin
      applyStimulus($urandom_range(9) < 7, int'($urandom_range(7)), int'($urandom_range(65535)),
                    $urandom_range(7) == 0, int'($urandom_range(7)), 1'($urandom_range(1)));
    end
    idleCycles(6);
    for (int f = 0; f < 8; f++) begin
      applyStimulus(1'b0, 0, 0, 1'b1, f, 1'b0);
      idleCycles(4);
    end

    $display("[TB] saturate versus wrap at narrow widths");
    smallStep(1'b1, 16'hFFFF);
    smallStep(1'b1, 16'hFFFF);
    smallRead(1'b0, 2 * 65535, 2, "sm_two_max");
    smallStep(1'b1, 1);
    smallStep(1'b1, 1);
    smallRead(1'b1, 2 * 65535 + 2, 4, "sm_overflow");
    smallRead(1'b0, 0, 0, "sm_after_clear");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
